simple_fetch_seq: RTL
=====================

Name: simple_fetch_seq

Overview:
Fetch and phase sequencer for the simple 8-bit ISA core. It owns the PC and the IF/ID/EX/WB phase counter, and issues instruction-memory reads. It presents INSTR and phase to the decode/execute stage, then applies that stage's pc_incr at the end of WB. It also provides run control (start, stall, HALT opcode) and retire reporting.

Parameters:
PC_W, 8, PC and imem address width; PC arithmetic is modulo 2^PC_W.
INSTR_W, 16, instruction width; opcode is INSTR[INSTR_W-1 -: 4].
RESET_PC, 0, PC value on reset.
HALT_OPCODE, 4'hF, opcode that stops the sequencer.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; leaves IDLE or HALT.
stall  in  1  freezes the sequencer for the cycle.
imem_rden  out  1  instruction-memory read enable.
imem_addr  out  PC_W  read address, equal to PC.
imem_dout  in  INSTR_W  read data, valid the cycle after imem_rden.
pc_incr  in  PC_W  PC increment from decode/ex; sampled in WB.
INSTR  out  INSTR_W  current instruction to decode/ex.
phase  out  2  IF=0, ID=1, EX=2, WB=3.
pc  out  PC_W  current PC.
running  out  1  high in states IF/ID/EX/WB.
halted  out  1  high in state HALT.
retire  out  1  one-cycle pulse when a WB cycle completes.
instr_cnt  out  16  count of retired instructions; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any state, mid-instruction included):
  - state=IDLE, pc=RESET_PC, instr_q=0, rd_pend_q=0, instr_cnt=0.
  - Outputs: imem_rden=0, phase=0, retire=0, running=0, halted=0.
- States: IDLE, S_IF, S_ID, S_EX, S_WB, HALT.
  - IDLE: start=1 and stall=0 -> S_IF.
  - HALT: start=1 and stall=0 -> S_IF.
  - start is ignored in every other state.
- stall=1 in any state:
  - state, pc, instr_q and instr_cnt hold.
  - imem_rden=0; retire=0.
  - stall takes priority over start.
- S_IF:
  - imem_rden = ~stall.
  - Unstalled -> S_ID; rd_pend_q <= 1 for exactly the following cycle.
- Instruction capture:
  - When rd_pend_q=1, instr_q <= imem_dout.
  - INSTR = rd_pend_q ? imem_dout : instr_q, so a stall in ID holds the captured word.
- S_ID:
  - If INSTR opcode == HALT_OPCODE: phase output is masked to 0 in that cycle; unstalled -> HALT with pc <= pc+1 (wraps). Decode/ex never sees the HALT opcode outside IF.
  - Otherwise -> S_EX.
- S_EX -> S_WB.
- S_WB (unstalled):
  - pc <= pc + pc_incr, truncated to PC_W (0xFE + 0x05 = 0x03).
  - retire=1 in this cycle.
  - instr_cnt increments, saturating at 16'hFFFF.
  - Next state -> S_IF (back-to-back, no idle cycle).
- phase output:
  - Encodes S_IF..S_WB; 0 in IDLE and HALT.
  - In HALT, INSTR holds the HALT word.
- Latency: 4 cycles per instruction with no stalls. First imem_rden occurs the cycle after the accepted start.
- imem_addr = pc in every cycle; imem_rden is asserted only in unstalled S_IF.

Test Plan:
- Reset, then idle 3 cycles -> pc=0x00, phase=0, imem_rden=0, running=0, instr_cnt=0. start -> imem_rden=1 on the next cycle.
- imem holds 0x3105 at 0, 0x3207 at 1, 0x4012 at 2; pc_incr=1 -> phases 0,1,2,3 repeat; pc goes 0,1,2,3; INSTR=0x3105 in ID..WB of the first instruction; 3 retire pulses; instr_cnt=3.
- pc=0xFE with a JZ instruction, pc_incr=0x05 in WB -> next IF has imem_addr=0x03.
- stall high for 3 cycles in ID, then in WB -> phase, INSTR and pc frozen; no retire while stalled; a single retire afterwards.
- 0xF000 at pc=2 -> phase=0 during that ID cycle; halted=1, pc=0x03, running=0. start -> fetch resumes at 0x03.
- Assert reset during S_EX -> pc=RESET_PC, IDLE, instr_cnt=0 immediately (async). start simultaneous with stall in IDLE -> remains IDLE.

Source files
------------

// File: rtl/simple_fetch_seq.sv
// Fetch and phase sequencer for the simple 8-bit ISA core.
// Owns the PC and the IF/ID/EX/WB phase, issues instruction-memory reads,
// presents the fetched word to decode/execute and applies its PC increment
// at the end of WB. Also provides start/stall/HALT run control and retire
// reporting.
module simple_fetch_seq #(
   parameter int              PC_W        = 8,
   parameter int              INSTR_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stall,
   output logic               imem_rden,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_dout,
   input  logic [PC_W-1:0]    pc_incr,
   output logic [INSTR_W-1:0] INSTR,
   output logic [1:0]         phase,
   output logic [PC_W-1:0]    pc,
   output logic               running,
   output logic               halted,
   output logic               retire,
   output logic [15:0]        instr_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S_IF = 3'd1,
      S_ID = 3'd2,
      S_EX = 3'd3,
      S_WB = 3'd4,
      HALT = 3'd5
   } state_t;

   state_t             state;
   logic [INSTR_W-1:0] instr_q;
   logic               rd_pend_q;
   logic               is_halt_op;

   // The word arrives from memory one cycle after the read; expose it straight
   // away in that cycle, afterwards from the capture register.
   assign INSTR      = rd_pend_q ? imem_dout : instr_q;
   assign is_halt_op = (INSTR[INSTR_W-1 -: 4] == HALT_OPCODE);

   assign imem_addr  = pc;
   assign imem_rden  = (state == S_IF) && !stall;
   assign retire     = (state == S_WB) && !stall;
   assign running    = (state == S_IF) || (state == S_ID) ||
                       (state == S_EX) || (state == S_WB);
   assign halted     = (state == HALT);

   // Phase seen by decode/ex; a HALT word in ID is hidden by reporting IF.
   always_comb begin
      phase = 2'd0;
      case (state)
         S_ID:    phase = is_halt_op ? 2'd0 : 2'd1;
         S_EX:    phase = 2'd2;
         S_WB:    phase = 2'd3;
         default: phase = 2'd0;
      endcase
   end

   // Sequencer state, PC, instruction capture and retire counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         instr_q   <= '0;
         rd_pend_q <= 1'b0;
         instr_cnt <= 16'd0;
      end else begin
         // Pending flag lasts exactly one cycle after an issued read.
         rd_pend_q <= (state == S_IF) && !stall;
         // Capture unconditionally so a stall in the first ID cycle keeps the word.
         if (rd_pend_q) begin
            instr_q <= imem_dout;
         end
         if (!stall) begin
            case (state)
               IDLE, HALT: begin
                  if (start) begin
                     state <= S_IF;
                  end
               end
               S_IF: begin
                  state <= S_ID;
               end
               S_ID: begin
                  if (is_halt_op) begin
                     state <= HALT;
                     pc    <= pc + PC_W'(1);
                  end else begin
                     state <= S_EX;
                  end
               end
               S_EX: begin
                  state <= S_WB;
               end
               S_WB: begin
                  state <= S_IF;
                  pc    <= pc + pc_incr;
                  if (instr_cnt != 16'hFFFF) begin
                     instr_cnt <= instr_cnt + 16'd1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
